// File: rtl/link_pkg.sv
// Shared definitions for the inter-board game link (receiver now, transmitter later).
package link_pkg;

    localparam int DEFAULT_CLKS_PER_BIT      = 564;        // 65 MHz / 115200 baud
    localparam int DEFAULT_LINK_TIMEOUT_CLKS = 6_500_000;  // 100 ms at 65 MHz

    typedef enum logic [1:0] {
        HEARTBEAT = 2'b00,
        THROW     = 2'b01,
        HIT_CAT   = 2'b10,
        HIT_DOG   = 2'b11
    } link_opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } link_rx_state_t;

    function automatic link_opcode_t link_opcode(input logic [7:0] frame_byte);
        return link_opcode_t'(frame_byte[7:6]);
    endfunction

endpackage

// File: rtl/link_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value chosen per use
// so an idle-high line never looks like an edge coming out of reset.
module link_sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= RESET_VAL;
                    sync_reg <= RESET_VAL;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/remote_link_rx.sv
// Link receiver: deserializes 8N1 frames from the peer board, decodes them into
// one-cycle game event pulses and tracks whether the link is still alive.
module remote_link_rx
    import link_pkg::*;
#(
    parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT,
    parameter int LINK_TIMEOUT_CLKS = DEFAULT_LINK_TIMEOUT_CLKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       throw_event,
    output logic [9:0] throw_force,
    output logic       hit_cat,
    output logic       hit_dog,
    output logic       link_up
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TO_W  = $clog2(LINK_TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(LINK_TIMEOUT_CLKS);

    logic rx_sync;

    link_sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_pin),
        .q   (rx_sync)
    );

    link_rx_state_t   state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             frame_ok;
    logic             frame_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (!rx_sync) state_next = START;
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) state_next = STOP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                // Leave at the mid-stop sample so a back-to-back start bit is caught.
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_sync) begin
                        frame_ok   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_sync) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    link_opcode_t opcode;
    assign opcode = link_opcode(shift_reg);

    logic [7:0]      rx_data_reg;
    logic            rx_valid_reg;
    logic            frame_err_reg;
    logic            throw_event_reg;
    logic [9:0]      throw_force_reg;
    logic            hit_cat_reg;
    logic            hit_dog_reg;
    logic            link_up_reg;
    logic [TO_W-1:0] timeout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            throw_event_reg <= 1'b0;
            throw_force_reg <= '0;
            hit_cat_reg     <= 1'b0;
            hit_dog_reg     <= 1'b0;
            link_up_reg     <= 1'b0;
            timeout_reg     <= '0;
        end else begin
            rx_valid_reg    <= frame_ok;
            frame_err_reg   <= frame_bad;
            throw_event_reg <= frame_ok && (opcode == THROW);
            hit_cat_reg     <= frame_ok && (opcode == HIT_CAT);
            hit_dog_reg     <= frame_ok && (opcode == HIT_DOG);
            if (frame_ok) begin
                rx_data_reg <= shift_reg;
                if (opcode == THROW) throw_force_reg <= {shift_reg[5:0], 4'b0000};
            end
            // link_up stays high for exactly LINK_TIMEOUT_CLKS cycles after a good frame.
            if (frame_ok) begin
                timeout_reg <= '0;
                link_up_reg <= 1'b1;
            end else if (timeout_reg != TO_LIMIT) begin
                timeout_reg <= timeout_reg + TO_W'(1);
                if (timeout_reg == TO_LIMIT - TO_W'(1)) link_up_reg <= 1'b0;
            end
        end
    end

    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign frame_err   = frame_err_reg;
    assign throw_event = throw_event_reg;
    assign throw_force = throw_force_reg;
    assign hit_cat     = hit_cat_reg;
    assign hit_dog     = hit_dog_reg;
    assign link_up     = link_up_reg;

endmodule
